// File: rtl/press_decode_pkg.sv
// Shared types and default timing for the press-count decoder.
// Optional feature macro: LONG_PRESS_EN (adds the long-press abort path).
package press_decode_pkg;

  // System clock the default timing constants are derived from.
  localparam int CLK_HZ = 12_000_000;

  // 10 ms of stable input accepts a level change.
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;

  // Roughly 0.7 s of quiet after the last release closes a sequence.
  localparam int DEF_GAP_CYCLES = 2 ** 23;

  // 2 s held high counts as a long press.
  localparam int DEF_LONG_CYCLES = 2 * CLK_HZ;

  // Decoder sequencing states. ABORT is reachable only with LONG_PRESS_EN.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESSED = 3'd1,
    GAP     = 3'd2,
    DONE    = 3'd3,
    ABORT   = 3'd4
  } state_t;

endpackage : press_decode_pkg

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a stable-sample debouncer.
// Emits the debounced level plus one-cycle rise/fall pulses that are
// high in the first cycle of the new level.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  // Bring the asynchronous input into the clk domain.
  // NOTE: non-blocking assignments make both flops sample the old value on
  // the same edge; blocking ones would collapse the chain into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  // NOTE: every state flop here is reset; an unreset counter would let a
  // power-up glitch toggle the level before the first real press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q   <= '0;
          level_q <= ~level_q;
          rise_q  <= ~level_q;
          fall_q  <= level_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule : input_debouncer

// File: rtl/press_count_decoder.sv
// Decodes a burst of presses into a count. After a quiet gap the final
// count is published on count_out with a one-cycle count_valid strobe.
// Optional feature macro: LONG_PRESS_EN -- a press held for LONG_CYCLES
// pulses long_press and abandons the sequence without a strobe.
module press_count_decoder
  import press_decode_pkg::*;
#(
  parameter int CNT_W           = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES
`ifdef LONG_PRESS_EN
  ,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             overflow,
  output logic             busy
`ifdef LONG_PRESS_EN
  ,
  output logic             long_press
`endif
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  logic [LONG_W-1:0] held_cnt_q;
  logic              long_press_q;
`endif

  logic             rise;
  logic             fall;
  logic             level_unused;

  state_t           state_q;
  logic [CNT_W-1:0] press_cnt_q;
  logic             ovf_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [CNT_W-1:0] count_out_q;
  logic             overflow_q;
  logic             count_valid_q;

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (pulse_in),
    .level(level_unused),
    .rise (rise),
    .fall (fall)
  );

  // Sequence FSM with press/gap counters and registered result outputs.
  // The result is loaded on the edge that enters DONE so the strobe is
  // high for exactly the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      press_cnt_q   <= '0;
      ovf_q         <= 1'b0;
      gap_cnt_q     <= '0;
      count_out_q   <= '0;
      overflow_q    <= 1'b0;
      count_valid_q <= 1'b0;
`ifdef LONG_PRESS_EN
      held_cnt_q    <= '0;
      long_press_q  <= 1'b0;
`endif
    end else begin
      count_valid_q <= 1'b0;
`ifdef LONG_PRESS_EN
      long_press_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q     <= PRESSED;
            press_cnt_q <= CNT_ONE;
            ovf_q       <= 1'b0;
`ifdef LONG_PRESS_EN
            held_cnt_q  <= '0;
`endif
          end
        end

        PRESSED: begin
          if (fall) begin
            state_q   <= GAP;
            gap_cnt_q <= '0;
`ifdef LONG_PRESS_EN
          end else if (held_cnt_q == LONG_LAST) begin
            state_q      <= ABORT;
            long_press_q <= 1'b1;
          end else begin
            held_cnt_q <= held_cnt_q + 1'b1;
`endif
          end
        end

        GAP: begin
          // A rise coinciding with the timeout extends the sequence.
          if (rise) begin
            state_q <= PRESSED;
`ifdef LONG_PRESS_EN
            held_cnt_q <= '0;
`endif
            if (press_cnt_q == CNT_MAX) begin
              ovf_q <= 1'b1;
            end else begin
              press_cnt_q <= press_cnt_q + 1'b1;
            end
          end else if (gap_cnt_q == GAP_LAST) begin
            state_q       <= DONE;
            count_out_q   <= press_cnt_q;
            overflow_q    <= ovf_q;
            count_valid_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end

        DONE: begin
          // A rise here is dropped; the level is already high, so the next
          // sequence needs a full release and a fresh press.
          state_q <= IDLE;
        end

`ifdef LONG_PRESS_EN
        ABORT: begin
          if (fall) begin
            state_q <= IDLE;
          end
        end
`endif

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign count_out   = count_out_q;
  assign count_valid = count_valid_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q != IDLE);
`ifdef LONG_PRESS_EN
  assign long_press  = long_press_q;
`endif

endmodule : press_count_decoder

// File: tb/tb_press_count_decoder.sv
// Directed bench for press_count_decoder with a result scoreboard.
// Expected results are queued when a sequence is driven and popped when
// count_valid fires. Define LONG_PRESS_EN to also exercise the long press.
module tb_press_count_decoder;

  localparam int CNT_W = 4;
  localparam int DB    = 4;
  localparam int GAP   = 32;
  localparam int LONG  = 64;

  // Raw release -> valid: 2 sync + DB debounce + 1 to enter GAP
  // + (GAP-1) increments + 1 to enter DONE.
  localparam int VALID_LAT = 2 + DB + 1 + (GAP - 1) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pulse_in;
  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic             overflow;
  logic             busy;
`ifdef LONG_PRESS_EN
  logic             long_press;
`endif

  press_count_decoder #(
    .CNT_W          (CNT_W),
    .DEBOUNCE_CYCLES(DB),
    .GAP_CYCLES     (GAP)
`ifdef LONG_PRESS_EN
    ,
    .LONG_CYCLES    (LONG)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pulse_in   (pulse_in),
    .count_out  (count_out),
    .count_valid(count_valid),
    .overflow   (overflow),
    .busy       (busy)
`ifdef LONG_PRESS_EN
    ,
    .long_press (long_press)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   strobe_cnt = 0;
  int   valid_cyc  = 0;
  int   last_release_cyc = 0;
  int   lp_cnt = 0;
  int   lp_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest queued result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && count_valid === 1'b1) begin
        strobe_cnt++;
        valid_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("count_out", 32'(count_out), 32'(e.cnt));
          check("overflow", 32'(overflow), 32'(e.ovf));
        end
      end
`ifdef LONG_PRESS_EN
      if (rst_n === 1'b1 && long_press === 1'b1) begin
        lp_cnt++;
        lp_cyc = cyc;
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input int c, input bit o);
    exp_t e;
    e.cnt = CNT_W'(c);
    e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic press(input int hi, input int lo);
    pulse_in = 1'b1;
    tick(hi);
    pulse_in = 1'b0;
    last_release_cyc = cyc;
    tick(lo);
  endtask

  // Wait (bounded) until every queued result has arrived and the FSM is idle.
  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_drained"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int s0;

    // Reset state.
    rst_n    = 1'b0;
    pulse_in = 1'b0;
    tick(3);
    check("rst_count_out", 32'(count_out), 32'd0);
    check("rst_count_valid", 32'(count_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Three clean presses.
    s0 = strobe_cnt;
    expect_seq(3, 1'b0);
    press(10, 10);
    check("three_busy_mid", 32'(busy), 32'd1);
    press(10, 10);
    press(10, 10);
    drain("three", 120);
    check("three_latency", 32'(valid_cyc - last_release_cyc), 32'(VALID_LAT));
    check("three_strobes", 32'(strobe_cnt - s0), 32'd1);
    check("three_busy_after", 32'(busy), 32'd0);

    // One press with 2-cycle glitches on both edges.
    s0 = strobe_cnt;
    expect_seq(1, 1'b0);
    pulse_in = 1'b1; tick(2);
    pulse_in = 1'b0; tick(2);
    pulse_in = 1'b1; tick(10);
    pulse_in = 1'b0; tick(2);
    pulse_in = 1'b1; tick(2);
    pulse_in = 1'b0;
    last_release_cyc = cyc;
    tick(1);
    drain("glitch", 120);
    check("glitch_latency", 32'(valid_cyc - last_release_cyc), 32'(VALID_LAT));
    check("glitch_strobes", 32'(strobe_cnt - s0), 32'd1);

    // 17 presses saturate at 15 with overflow; the next sequence clears it.
    expect_seq(15, 1'b1);
    for (int i = 0; i < 17; i++) press(10, 10);
    drain("ovf17", 120);
    expect_seq(2, 1'b0);
    press(10, 10);
    press(10, 10);
    drain("after_ovf", 120);

    // Rise lands exactly when gap_cnt = GAP-1: the sequence continues.
    s0 = strobe_cnt;
    expect_seq(2, 1'b0);
    press(10, GAP);
    press(10, 10);
    drain("rise_at_timeout", 120);
    check("rise_at_timeout_strobes", 32'(strobe_cnt - s0), 32'd1);

    // Rise one cycle later lands in DONE: it is dropped, no second sequence.
    s0 = strobe_cnt;
    expect_seq(1, 1'b0);
    press(10, GAP + 1);
    press(10, 10);
    drain("rise_in_done", 120);
    tick(60);
    check("rise_in_done_strobes", 32'(strobe_cnt - s0), 32'd1);
    check("rise_in_done_busy", 32'(busy), 32'd0);

    // Reset in GAP after two presses discards the sequence.
    s0 = strobe_cnt;
    press(10, 10);
    press(10, 15);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick(1);
    check("midrst_count_out", 32'(count_out), 32'd0);
    check("midrst_count_valid", 32'(count_valid), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(2);
    expect_seq(1, 1'b0);
    press(10, 10);
    drain("post_reset", 120);
    check("post_reset_strobes", 32'(strobe_cnt - s0), 32'd1);

`ifdef LONG_PRESS_EN
    // Held 100 cycles: long_press fires once, no strobe, count_out kept.
    s0 = strobe_cnt;
    begin
      int press_cyc;
      pulse_in  = 1'b1;
      press_cyc = cyc;
      tick(100);
      pulse_in = 1'b0;
      tick(60);
      // Raw edge -> debounced rise 6, PRESSED entry +1, LONG-1 increments,
      // +1 to enter ABORT with the pulse.
      check("long_pulses", 32'(lp_cnt), 32'd1);
      check("long_latency", 32'(lp_cyc - press_cyc), 32'(2 + DB + 1 + (LONG - 1) + 1));
    end
    check("long_strobes", 32'(strobe_cnt - s0), 32'd0);
    check("long_count_kept", 32'(count_out), 32'd1);
    check("long_busy_after", 32'(busy), 32'd0);
    expect_seq(1, 1'b0);
    press(10, 10);
    drain("after_long", 120);
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_press_count_decoder
